// File: rtl/ne16_input_buffer_loader_pkg.sv
// Shared types and constants for the NE16 input buffer fill stage.
package ne16_input_buffer_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } ne16_inbuf_loader_state_e;

    localparam int unsigned NE16_INBUF_NUM_WORDS = 25;

endpackage

// File: rtl/ne16_input_buffer_loader.sv
// Fill stage ahead of the NE16 input buffer SCM: turns streamer beats into registered writes.
// Optional zero-padding of selected addresses is enabled with NE16_INPUT_BUFFER_LOADER_PAD_EN.
module ne16_input_buffer_loader
    import ne16_input_buffer_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_WORDS  = NE16_INBUF_NUM_WORDS,
    localparam int unsigned NB_WIDTH  = $clog2(NUM_WORDS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [NB_WIDTH-1:0]   nb_words_i,
    input  logic [NUM_WORDS-1:0]  pad_mask_i,
    input  logic                  release_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  buf_we_o,
    output logic [ADDR_WIDTH-1:0] buf_waddr_o,
    output logic [DATA_WIDTH-1:0] buf_wdata_o,
    output logic                  buf_clear_o,
    output logic                  busy_o,
    output logic                  full_o,
    output logic                  done_o
);

    localparam int unsigned EXT_WIDTH = ((ADDR_WIDTH > NB_WIDTH) ? ADDR_WIDTH : NB_WIDTH) + 1;

    ne16_inbuf_loader_state_e state_q;
    logic [ADDR_WIDTH-1:0]    wordCnt_q;
    logic [ADDR_WIDTH-1:0]    waddr_q;
    logic [NB_WIDTH-1:0]      nbWords_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     we_q;
    logic                     bufClear_q;
    logic                     done_q;

    logic [NB_WIDTH-1:0]      nbClamped;
    logic                     padWord;
    logic                     inReady;
    logic                     commit;
    logic                     lastWord;

    assign nbClamped = ((nb_words_i == '0) || (nb_words_i > NB_WIDTH'(NUM_WORDS)))
                       ? NB_WIDTH'(NUM_WORDS) : nb_words_i;

`ifdef NE16_INPUT_BUFFER_LOADER_PAD_EN
    logic [NUM_WORDS-1:0] padMask_q;

    // The mask is captured together with the word count so it stays stable for the whole tile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            padMask_q <= '0;
        end else if (!clear_i && (state_q == IDLE) && start_i) begin
            padMask_q <= pad_mask_i;
        end
    end

    assign padWord = (state_q == LOAD) && padMask_q[wordCnt_q];
`else
    logic unusedPadMask;
    assign unusedPadMask = ^pad_mask_i;
    assign padWord       = 1'b0;
`endif

    // A pad address commits by itself; a real address needs a beat.
    assign inReady  = (state_q == LOAD) && !padWord && !clear_i;
    assign commit   = (state_q == LOAD) && !clear_i && (padWord || in_valid_i);
    assign lastWord = (EXT_WIDTH'(wordCnt_q) + EXT_WIDTH'(1)) == EXT_WIDTH'(nbWords_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wordCnt_q  <= '0;
            nbWords_q  <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            bufClear_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            bufClear_q <= 1'b0;
            if (clear_i) begin
                state_q    <= IDLE;
                wordCnt_q  <= '0;
                bufClear_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q   <= LOAD;
                            nbWords_q <= nbClamped;
                            wordCnt_q <= '0;
                        end
                    end
                    LOAD: begin
                        if (commit) begin
                            we_q    <= 1'b1;
                            waddr_q <= wordCnt_q;
                            wdata_q <= padWord ? '0 : in_data_i;
                            if (lastWord) begin
                                state_q <= FULL;
                                done_q  <= 1'b1;
                            end else begin
                                wordCnt_q <= wordCnt_q + 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (release_i) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready_o  = inReady;
    assign buf_we_o    = we_q;
    assign buf_waddr_o = waddr_q;
    assign buf_wdata_o = wdata_q;
    assign buf_clear_o = bufClear_q;
    assign busy_o      = (state_q != IDLE);
    assign full_o      = (state_q == FULL);
    assign done_o      = done_q;

endmodule

// File: tb/tb_ne16_input_buffer_loader.sv
// Randomized self-checking bench for ne16_input_buffer_loader against a tile-level reference model.
// Pad scenarios follow NE16_INPUT_BUFFER_LOADER_PAD_EN when it is defined for the build.
module tb_ne16_input_buffer_loader;

    localparam int NW = 25;

`ifdef NE16_INPUT_BUFFER_LOADER_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic          start_i = 1'b0;
    logic [4:0]    nb_words_i = '0;
    logic [NW-1:0] pad_mask_i = '0;
    logic          release_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [127:0]  in_data_i = '0;
    logic          buf_we_o;
    logic [4:0]    buf_waddr_o;
    logic [127:0]  buf_wdata_o;
    logic          buf_clear_o;
    logic          busy_o;
    logic          full_o;
    logic          done_o;

    ne16_input_buffer_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .nb_words_i  (nb_words_i),
        .pad_mask_i  (pad_mask_i),
        .release_i   (release_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .buf_we_o    (buf_we_o),
        .buf_waddr_o (buf_waddr_o),
        .buf_wdata_o (buf_wdata_o),
        .buf_clear_o (buf_clear_o),
        .busy_o      (busy_o),
        .full_o      (full_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nBad = 0;
    int beatsSeen = 0;

    // Reference model: where the tile stands, not how the RTL encodes it.
    bit            mLoading = 1'b0;
    bit            mHolding = 1'b0;
    int            mWritten = 0;
    int            mTarget = 0;
    logic [NW-1:0] mMask = '0;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: checks the combinational ready before the edge and the
    // registered outputs just after it.
    task automatic applyStimulus(input bit st, input int nb, input logic [NW-1:0] pm,
                                 input bit rel, input bit vld, input logic [127:0] d,
                                 input bit clr);
        bit           pad;
        bit           expReady;
        bit           expWe;
        bit           expDone;
        int           expAddr;
        logic [127:0] expData;
        @(negedge clk);
        start_i    = st;
        nb_words_i = nb[4:0];
        pad_mask_i = pm;
        release_i  = rel;
        in_valid_i = vld;
        in_data_i  = d;
        clear_i    = clr;
        #1;
        pad      = mLoading && PAD_ON && mMask[mWritten];
        expReady = mLoading && !pad && !clr;
        checkOutput("in_ready", {127'd0, in_ready_o}, {127'd0, expReady});
        if (in_valid_i && in_ready_o) beatsSeen++;

        expWe   = 1'b0;
        expDone = 1'b0;
        expAddr = 0;
        expData = '0;
        if (clr) begin
            mLoading = 1'b0;
            mHolding = 1'b0;
            mWritten = 0;
        end else if (mLoading) begin
            if (pad || (vld && expReady)) begin
                expWe   = 1'b1;
                expAddr = mWritten;
                expData = pad ? 128'd0 : d;
                mWritten++;
                if (mWritten == mTarget) begin
                    expDone  = 1'b1;
                    mLoading = 1'b0;
                    mHolding = 1'b1;
                end
            end
        end else if (mHolding) begin
            if (rel) mHolding = 1'b0;
        end else if (st) begin
            mLoading = 1'b1;
            mWritten = 0;
            mTarget  = (nb == 0 || nb > NW) ? NW : nb;
            mMask    = pm;
        end

        @(posedge clk);
        #1;
        checkOutput("buf_we", {127'd0, buf_we_o}, {127'd0, expWe});
        if (expWe) begin
            checkOutput("buf_waddr", {123'd0, buf_waddr_o}, 128'(expAddr));
            checkOutput("buf_wdata", buf_wdata_o, expData);
        end
        checkOutput("buf_clear", {127'd0, buf_clear_o}, {127'd0, clr});
        checkOutput("done", {127'd0, done_o}, {127'd0, expDone});
        checkOutput("full", {127'd0, full_o}, {127'd0, mHolding});
        checkOutput("busy", {127'd0, busy_o}, {127'd0, (mLoading || mHolding)});
    endtask

    task automatic idleCycle(input bit vld, input logic [127:0] d);
        applyStimulus(1'b0, 0, '0, 1'b0, vld, d, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("rst_we", {127'd0, buf_we_o}, 128'd0);
        checkOutput("rst_ready", {127'd0, in_ready_o}, 128'd0);
        checkOutput("rst_flags", {124'd0, busy_o, full_o, done_o, buf_clear_o}, 128'd0);
        checkOutput("rst_waddr", {123'd0, buf_waddr_o}, 128'd0);
        checkOutput("rst_wdata", buf_wdata_o, 128'd0);
        mLoading = 1'b0;
        mHolding = 1'b0;
        mWritten = 0;
        mMask    = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [127:0] rndData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        $display("[TB] starting");
        #3;
        doReset();

        // Full tile with a continuous stream, then held FULL while beats are offered.
        applyStimulus(1'b1, 25, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 25; k++) idleCycle(1'b1, 128'(k));
        for (int k = 0; k < 10; k++) idleCycle(1'b1, rndData());
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b1, rndData(), 1'b0);
        idleCycle(1'b0, '0);

        // Nine words with a bursty stream.
        applyStimulus(1'b1, 9, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 20; k++) idleCycle((k % 2) == 0, rndData());
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, '0, 1'b0);

        // Clear in the middle of a tile, with a handshake in the clear cycle.
        applyStimulus(1'b1, 25, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 12; k++) idleCycle(1'b1, rndData());
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b1, rndData(), 1'b1);
        applyStimulus(1'b1, 3, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) idleCycle(1'b1, rndData());
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, '0, 1'b0);

        // Zero and oversized counts clamp to a full tile; start during LOAD is ignored.
        applyStimulus(1'b1, 0, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) idleCycle(1'b1, rndData());
        applyStimulus(1'b1, 2, '0, 1'b0, 1'b1, rndData(), 1'b0);
        for (int k = 0; k < 22; k++) idleCycle(1'b1, rndData());
        applyStimulus(1'b1, 4, '0, 1'b1, 1'b0, '0, 1'b0);
        idleCycle(1'b0, '0);
        applyStimulus(1'b1, 31, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 27; k++) idleCycle(1'b1, rndData());
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, '0, 1'b0);

        // Row 0 padded: beats consumed depends on whether padding is built in.
        beatsSeen = 0;
        applyStimulus(1'b1, 25, 25'h1F, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 30; k++) idleCycle(1'b1, rndData());
        checkOutput("pad_beats", 128'(beatsSeen), PAD_ON ? 128'd20 : 128'd25);
        applyStimulus(1'b0, 0, '0, 1'b1, 1'b0, '0, 1'b0);

        // Random traffic across all controls.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 99) < 30, int'($urandom_range(0, 31)),
                          NW'({$urandom}), $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 70, rndData(),
                          $urandom_range(0, 99) < 2);
        end

        // Asynchronous reset in the middle of a load discards progress.
        applyStimulus(1'b0, 0, '0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 10, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) idleCycle(1'b1, rndData());
        doReset();
        idleCycle(1'b1, rndData());
        applyStimulus(1'b1, 2, '0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) idleCycle(1'b1, rndData());

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
